// File: rtl/router_ram_fifo_ctrl.sv
// Queue controller for the router packet RAM: stream-to-RAM writes, latency-hiding read prefetch into a small output buffer.
// Optional error checking (err_ovf, err_udf, dbg_expect, OB overflow assertion) is enabled by defining ROUTER_FIFO_ERR_CHK_EN.
module router_ram_fifo_ctrl #(
   parameter int unsigned DEPTH    = 12,
   parameter int unsigned WIDTH    = 73,
   parameter int unsigned ADDR_W   = 4,
   parameter int unsigned RD_LAT   = 2,
   parameter int unsigned OB_DEPTH = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  out_data,
   output logic              ram_wr_en,
   output logic [ADDR_W-1:0] ram_wr_addr,
   output logic [WIDTH-1:0]  ram_wr_data,
   output logic              ram_rd_en,
   output logic [ADDR_W-1:0] ram_rd_addr,
   input  logic [WIDTH-1:0]  ram_rd_data,
`ifdef ROUTER_FIFO_ERR_CHK_EN
   input  logic              dbg_expect,
   output logic              err_ovf,
   output logic              err_udf,
`endif
   output logic [ADDR_W+1:0] count
);

   localparam int unsigned CW    = ADDR_W + 2;
   localparam int unsigned OB_AW = (OB_DEPTH > 1) ? $clog2(OB_DEPTH) : 1;

   logic [ADDR_W-1:0] wr_ptr, rd_ptr;
   logic [ADDR_W:0]   ram_cnt;
   logic [RD_LAT-1:0] pipe;
   logic [WIDTH-1:0]  ob_mem [OB_DEPTH];
   logic [OB_AW-1:0]  ob_head, ob_tail;
   logic [CW-1:0]     ob_cnt, inflight_cnt;
   logic              push, pop, issue, capture;

   function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
      return (p == ADDR_W'(DEPTH - 1)) ? '0 : p + ADDR_W'(1);
   endfunction

   function automatic logic [OB_AW-1:0] ob_inc(input logic [OB_AW-1:0] p);
      return (p == OB_AW'(OB_DEPTH - 1)) ? '0 : p + OB_AW'(1);
   endfunction

   always_comb begin
      inflight_cnt = '0;
      for (int unsigned i = 0; i < RD_LAT; i++)
         inflight_cnt = inflight_cnt + CW'(pipe[i]);
   end

   // Reads already in flight are reserved buffer slots, so the buffer can never overflow.
   always_comb begin
      in_ready  = (ram_cnt < (ADDR_W+1)'(DEPTH));
      push      = in_valid & in_ready;
      out_valid = (ob_cnt != '0);
      pop       = out_valid & out_ready;
      issue     = (ram_cnt != '0) && ((ob_cnt + inflight_cnt - CW'(pop)) < CW'(OB_DEPTH));
      capture   = pipe[RD_LAT-1];
   end

   assign ram_wr_en   = push;
   assign ram_wr_addr = wr_ptr;
   assign ram_wr_data = in_data;
   assign ram_rd_en   = issue;
   assign ram_rd_addr = rd_ptr;
   assign out_data    = ob_mem[ob_head];
   assign count       = CW'(ram_cnt) + inflight_cnt + ob_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         ram_cnt <= '0;
         pipe    <= '0;
      end else begin
         if (push)
            wr_ptr <= ptr_inc(wr_ptr);
         if (issue)
            rd_ptr <= ptr_inc(rd_ptr);
         ram_cnt <= ram_cnt + (ADDR_W+1)'(push) - (ADDR_W+1)'(issue);
         pipe[0] <= issue;
         for (int unsigned i = 1; i < RD_LAT; i++)
            pipe[i] <= pipe[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ob_head <= '0;
         ob_tail <= '0;
         ob_cnt  <= '0;
         for (int unsigned i = 0; i < OB_DEPTH; i++)
            ob_mem[i] <= '0;
      end else begin
         if (capture) begin
            ob_mem[ob_tail] <= ram_rd_data;
            ob_tail         <= ob_inc(ob_tail);
         end
         if (pop)
            ob_head <= ob_inc(ob_head);
         ob_cnt <= ob_cnt + CW'(capture) - CW'(pop);
      end
   end

`ifdef ROUTER_FIFO_ERR_CHK_EN
   logic [4:0] stall_cnt;

   // stall_cnt holds the number of earlier consecutive blocked cycles; the 17th sets the flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
         err_ovf   <= 1'b0;
         err_udf   <= 1'b0;
      end else begin
         if (in_valid && !in_ready) begin
            if (stall_cnt >= 5'd16)
               err_ovf <= 1'b1;
            if (stall_cnt != '1)
               stall_cnt <= stall_cnt + 5'd1;
         end else begin
            stall_cnt <= '0;
         end
         if (out_ready && !out_valid && dbg_expect)
            err_udf <= 1'b1;
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (!rst)
         assert (!(capture && (ob_cnt == CW'(OB_DEPTH))));
   end
`endif
`endif

endmodule

// File: tb/tb_router_ram_fifo_ctrl.sv
// Self-checking bench for router_ram_fifo_ctrl: behavioural 2-cycle RAM, scoreboard queue, table-driven latency vectors.
module tb_router_ram_fifo_ctrl;

   localparam int unsigned W  = 73;
   localparam int unsigned AW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, in_ready, out_valid, out_ready;
   logic [W-1:0]  in_data, out_data;
   logic          ram_wr_en, ram_rd_en;
   logic [AW-1:0] ram_wr_addr, ram_rd_addr;
   logic [W-1:0]  ram_wr_data, ram_rd_data;
   logic [AW+1:0] count;
`ifdef ROUTER_FIFO_ERR_CHK_EN
   logic          err_ovf, err_udf;
`endif

   router_ram_fifo_ctrl #(.DEPTH(12), .WIDTH(W), .ADDR_W(AW), .RD_LAT(2), .OB_DEPTH(3)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
      .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
`ifdef ROUTER_FIFO_ERR_CHK_EN
      .dbg_expect(1'b0), .err_ovf(err_ovf), .err_udf(err_udf),
`endif
      .count(count)
   );

   always #5 clk = ~clk;

   // Behavioural RAM: data appears two cycles after the read enable.
   logic [W-1:0] mem [12];
   logic [W-1:0] rd_d1, rd_d2;
   always @(posedge clk) begin
      if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
      if (ram_rd_en) rd_d1 <= mem[ram_rd_addr];
      rd_d2 <= rd_d1;
   end
   assign ram_rd_data = rd_d2;

   int n_chk = 0, n_err = 0;
   int cyc = 0, accepted = 0, pops = 0, rd_issues = 0;
   logic [W-1:0] sb [$];
   logic [W-1:0] last_pop;
   logic [AW-1:0] exp_wa, exp_ra;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard monitor; count must equal words accepted but not yet delivered.
   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
         exp_wa = '0;
         exp_ra = '0;
      end else begin
         chk("count_vs_model", count, sb.size());
         chk("count_le_15", count <= 15, 1'b1);
         chk("wr_en_is_push", ram_wr_en, in_valid && in_ready);
         if (ram_wr_en) begin
            chk("wr_addr", ram_wr_addr, exp_wa);
            chk("wr_data", ram_wr_data, in_data);
            exp_wa = (exp_wa == 4'd11) ? 4'd0 : exp_wa + 4'd1;
         end
         if (ram_rd_en) begin
            chk("rd_addr", ram_rd_addr, exp_ra);
            exp_ra = (exp_ra == 4'd11) ? 4'd0 : exp_ra + 4'd1;
            rd_issues++;
         end
         if (in_valid && in_ready) begin
            sb.push_back(in_data);
            accepted++;
         end
         if (out_valid && out_ready) begin
            n_chk++;
            if (sb.size() == 0) begin
               n_err++;
               $display("FAIL pop_empty: out_valid with nothing expected, data %0h", out_data);
            end else begin
               chk("out_data", out_data, sb.pop_front());
            end
            last_pop = out_data;
            pops++;
         end
      end
   end

   typedef struct {
      logic iv; logic ordy;
      logic exp_ir; logic exp_ov; int exp_cnt; logic exp_we; logic exp_re;
   } vec_t;
   vec_t tbl [11];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic drain(input int budget);
      int n = 0;
      in_valid = 1'b0; out_ready = 1'b1;
      while (count != 0 && n < budget) begin step(); n++; end
      chk("drain_count", count, 0);
      chk("drain_sb_empty", sb.size(), 0);
   endtask

   function automatic logic [W-1:0] rnd();
      return {$urandom, $urandom, $urandom};
   endfunction

   initial begin
      logic [W-1:0] d;
      int a0, p0, r0, n, first_c, last_c;
      d = 73'h1_2345_6789_ABCD_EF01;
      in_data = '0;
      for (int i = 0; i < 5; i++) tbl[i] = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0};
      tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0};
      tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b1};
      tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b0};
      tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b0};
      tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1, 1'b0, 1'b0};
      tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0};

      // Reset values and single-word latency
      do_reset();
      for (int i = 0; i < 11; i++) begin
         in_valid = tbl[i].iv; out_ready = tbl[i].ordy; in_data = d;
         @(negedge clk);
         if (i == 0) begin
            chk("rst_out_data", out_data, 0);
            chk("rst_wr_addr", ram_wr_addr, 0);
            chk("rst_rd_addr", ram_rd_addr, 0);
         end
         chk($sformatf("t%0d_in_ready", i), in_ready, tbl[i].exp_ir);
         chk($sformatf("t%0d_out_valid", i), out_valid, tbl[i].exp_ov);
         chk($sformatf("t%0d_count", i), count, tbl[i].exp_cnt);
         chk($sformatf("t%0d_wr_en", i), ram_wr_en, tbl[i].exp_we);
         chk($sformatf("t%0d_rd_en", i), ram_rd_en, tbl[i].exp_re);
         if (tbl[i].exp_we) chk("t_wr_addr0", ram_wr_addr, 0);
         if (tbl[i].exp_re) chk("t_rd_addr0", ram_rd_addr, 0);
         if (tbl[i].exp_ov) chk("t_out_data", out_data, d);
         step();
      end

      // Fill while stalled: 20 offered, 15 accepted, 3 reads issued
      do_reset();
      a0 = accepted; r0 = rd_issues;
      in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         in_data = rnd();
         step();
         if (accepted - a0 >= 15) chk("full_in_ready", in_ready, 1'b0);
      end
      in_valid = 1'b0;
      chk("fill_accepted", accepted - a0, 15);
      chk("fill_count", count, 15);
      chk("fill_rd_issues", rd_issues - r0, 3);

      // Full with simultaneous push and pop: nothing lost, occupancy stays at capacity-1
      in_valid = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         in_data = rnd();
         step();
         chk("full_stream_count_ge14", count >= 14, 1'b1);
      end
      drain(100);

      // Wrap and streaming: 40 words, one per cycle after the pipeline fills
      do_reset();
      a0 = accepted; p0 = pops; first_c = -1; last_c = -1; n = 0;
      out_ready = 1'b1; in_valid = 1'b1;
      while (pops < p0 + 40 && n < 200) begin
         in_data = rnd();
         step(); n++;
         if (accepted >= a0 + 40) in_valid = 1'b0;
         if (first_c < 0 && pops >= p0 + 1) first_c = cyc;
         if (last_c < 0 && pops >= p0 + 40) last_c = cyc;
      end
      in_valid = 1'b0;
      chk("wrap_pops", pops - p0, 40);
      chk("wrap_throughput", last_c - first_c, 39);

      // Random backpressure, 500 words
      do_reset();
      a0 = accepted; p0 = pops; n = 0;
      while (pops < p0 + 500 && n < 20000) begin
         in_valid  = (accepted < a0 + 500) && ($urandom_range(0, 99) < 70);
         out_ready = ($urandom_range(0, 99) < 50);
         in_data   = rnd();
         step(); n++;
      end
      chk("rand_accepted", accepted - a0, 500);
      chk("rand_pops", pops - p0, 500);
      drain(100);

      // Reset with two reads in flight and words stored
      do_reset();
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin in_data = rnd(); step(); end
      in_valid = 1'b0; rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_count", count, 0);
      chk("midrst_out_valid", out_valid, 1'b0);
      chk("midrst_in_ready", in_ready, 1'b1);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("midrst_no_capture", out_valid, 1'b0);
      end
      p0 = pops; n = 0;
      d = rnd();
      in_data = d; in_valid = 1'b1; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      while (pops < p0 + 1 && n < 20) begin step(); n++; end
      for (int i = 0; i < 4; i++) step();
      chk("midrst_one_pop", pops - p0, 1);
      chk("midrst_new_word", last_pop, d);
      chk("midrst_empty_after", out_valid, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
